// File: rtl/clock_reconfig_sequencer_if.sv
// ---------------------------------------------------------------------------
// clock_reconfig_sequencer_if
//
// Purpose:
//   Bundles the signals that the clock reconfiguration sequencer exchanges
//   with the rest of the video system. These are the mode-change request from
//   the mode selector, the PLL lock status, the ICS644 S-pin drive, the PLL
//   reset, the video output enable and the status flags.
//
// Signals:
//   config_changed   mode selector -> sequencer, 1-cycle new-mode pulse
//   clock_config_in  mode selector -> sequencer, requested ICS644 S setting
//   pll_locked       PLL -> sequencer, lock (already synchronised)
//   clock_config_S   sequencer -> ICS644 S pins
//   pll_reset        sequencer -> PLL areset (active high)
//   output_enable    sequencer -> HDMI output, 1 = live, 0 = blanked
//   busy             sequencer status, 1 whenever not in normal running
//   fault            sequencer status, 1 when lock could not be achieved
//
// Modports:
//   master  the environment side (mode selector / PLL / output stage)
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface clock_reconfig_sequencer_if;
    logic       config_changed;
    logic [3:0] clock_config_in;
    logic       pll_locked;
    logic [3:0] clock_config_S;
    logic       pll_reset;
    logic       output_enable;
    logic       busy;
    logic       fault;

    modport master (
        output config_changed,
        output clock_config_in,
        output pll_locked,
        input  clock_config_S,
        input  pll_reset,
        input  output_enable,
        input  busy,
        input  fault
    );

    modport slave (
        input  config_changed,
        input  clock_config_in,
        input  pll_locked,
        output clock_config_S,
        output pll_reset,
        output output_enable,
        output busy,
        output fault
    );
endinterface

// File: rtl/clock_reconfig_sequencer.sv
// ---------------------------------------------------------------------------
// clock_reconfig_sequencer
//
// Purpose:
//   Sequences a video clock change. The video output is blanked first. Then
//   the ICS644 S pins are programmed and the synthesizer is given time to
//   settle. After that the downstream PLL is reset and its lock is qualified,
//   and finally the output is unblanked. A lock that does not arrive in time
//   is retried a limited number of times. After the last retry a fault is
//   latched until the next mode change.
//
// Ports:
//   clock    system clock
//   reset_n  synchronous active-low reset
//   bus      clock_reconfig_sequencer_if.slave (see interface header)
//
// Parameters:
//   BLANK_CYCLES, SETTLE_CYCLES, PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES
//     durations in clock cycles, each in the range 1 .. 2^24-1
//   MAX_RETRIES
//     lock retries before FAULT, in the range 0 .. 3
// ---------------------------------------------------------------------------
module clock_reconfig_sequencer #(
    parameter int unsigned BLANK_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES  = 65536,
    parameter int unsigned PLL_RST_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT   = 1048576,
    parameter int unsigned STABLE_CYCLES  = 4096,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    clock_reconfig_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        RUN,
        BLANK,
        PROGRAM,
        SETTLE,
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        FAULT
    } state_t;

    // Each timed state loads N-1 on entry, so it lasts exactly N cycles.
    localparam logic [23:0] BLANK_LOAD   = 24'(BLANK_CYCLES - 1);
    localparam logic [23:0] SETTLE_LOAD  = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] PLL_RST_LOAD = 24'(PLL_RST_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LOAD = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] STABLE_LOAD  = 24'(STABLE_CYCLES - 1);
    localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRIES);

    state_t      state;
    logic [23:0] counter;
    logic [1:0]  retries;
    logic [3:0]  config_s;
    // Packed as {pll_reset, output_enable, busy, fault}.
    logic [3:0]  out_flags;

    // The output flags are a pure function of the state being entered. They
    // are written on the same edge as the state, which keeps the outputs
    // registered and aligned with the state change.
    function automatic logic [3:0] flags_for(input state_t s);
        case (s)
            RUN:                    flags_for = 4'b0100;
            PROGRAM, SETTLE,
            PLL_RST:                flags_for = 4'b1010;
            FAULT:                  flags_for = 4'b0011;
            default:                flags_for = 4'b0010;
        endcase
    endfunction

    // Main sequencer. A config_changed pulse during any in-progress step
    // (BLANK through STABLE) has priority over timers and lock events. It
    // restarts at PROGRAM so that the newest requested setting is latched.
    // The output is already blanked in those states, so no new blank period
    // is needed. The counter only decrements while it is non-zero, so it
    // never wraps.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= PROGRAM;
            counter   <= '0;
            retries   <= '0;
            config_s  <= 4'h0;
            out_flags <= flags_for(PROGRAM);
        end else if (bus.config_changed && state != RUN && state != FAULT) begin
            state     <= PROGRAM;
            counter   <= '0;
            out_flags <= flags_for(PROGRAM);
        end else begin
            case (state)
                RUN: begin
                    if (bus.config_changed) begin
                        state     <= BLANK;
                        counter   <= BLANK_LOAD;
                        out_flags <= flags_for(BLANK);
                    end else if (!bus.pll_locked) begin
                        state     <= WAIT_LOCK;
                        counter   <= TIMEOUT_LOAD;
                        retries   <= '0;
                        out_flags <= flags_for(WAIT_LOCK);
                    end
                end
                BLANK: begin
                    if (counter == '0) begin
                        state     <= PROGRAM;
                        out_flags <= flags_for(PROGRAM);
                    end else begin
                        counter <= counter - 24'd1;
                    end
                end
                PROGRAM: begin
                    config_s  <= bus.clock_config_in;
                    retries   <= '0;
                    state     <= SETTLE;
                    counter   <= SETTLE_LOAD;
                    out_flags <= flags_for(SETTLE);
                end
                SETTLE: begin
                    if (counter == '0) begin
                        state     <= PLL_RST;
                        counter   <= PLL_RST_LOAD;
                        out_flags <= flags_for(PLL_RST);
                    end else begin
                        counter <= counter - 24'd1;
                    end
                end
                PLL_RST: begin
                    if (counter == '0) begin
                        state     <= WAIT_LOCK;
                        counter   <= TIMEOUT_LOAD;
                        out_flags <= flags_for(WAIT_LOCK);
                    end else begin
                        counter <= counter - 24'd1;
                    end
                end
                WAIT_LOCK: begin
                    if (bus.pll_locked) begin
                        state     <= STABLE;
                        counter   <= STABLE_LOAD;
                        out_flags <= flags_for(STABLE);
                    end else if (counter == '0) begin
                        if (retries < RETRY_LIMIT) begin
                            state     <= PLL_RST;
                            counter   <= PLL_RST_LOAD;
                            retries   <= retries + 2'd1;
                            out_flags <= flags_for(PLL_RST);
                        end else begin
                            state     <= FAULT;
                            out_flags <= flags_for(FAULT);
                        end
                    end else begin
                        counter <= counter - 24'd1;
                    end
                end
                STABLE: begin
                    if (!bus.pll_locked) begin
                        state     <= WAIT_LOCK;
                        counter   <= TIMEOUT_LOAD;
                        out_flags <= flags_for(WAIT_LOCK);
                    end else if (counter == '0) begin
                        state     <= RUN;
                        out_flags <= flags_for(RUN);
                    end else begin
                        counter <= counter - 24'd1;
                    end
                end
                FAULT: begin
                    if (bus.config_changed) begin
                        state     <= BLANK;
                        counter   <= BLANK_LOAD;
                        out_flags <= flags_for(BLANK);
                    end
                end
                default: begin
                    state     <= PROGRAM;
                    counter   <= '0;
                    out_flags <= flags_for(PROGRAM);
                end
            endcase
        end
    end

    assign bus.clock_config_S = config_s;
    assign bus.pll_reset      = out_flags[3];
    assign bus.output_enable  = out_flags[2];
    assign bus.busy           = out_flags[1];
    assign bus.fault          = out_flags[0];

endmodule

// File: tb/tb_clock_reconfig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clock_reconfig_sequencer
//
// Purpose:
//   Directed bench for clock_reconfig_sequencer. It uses small parameters:
//   BLANK=4, SETTLE=8, PLL_RST=4, TIMEOUT=32, STABLE=4, RETRIES=2.
//
//   The stimulus process records every output change it expects. Each record
//   holds the packed output word {S[3:0], pll_reset, output_enable, busy,
//   fault} and the absolute clock edge at which the change must appear.
//   The monitor process watches the outputs on every falling edge. For each
//   change it sees, it takes the oldest expectation and checks both the value
//   and the edge.
//
//   Timing rule used for the hand-computed edges: if PROGRAM is entered at
//   edge P, then S changes at P+1, pll_reset drops at P+13 (1+8+4) and, with
//   lock present, the output goes live at P+18.
// ---------------------------------------------------------------------------
module tb_clock_reconfig_sequencer;

    logic clock;
    logic reset_n;
    int   cyc;
    logic armed;
    logic [7:0] snap;
    logic [7:0] prev;

    int n_compared;
    int n_mismatched;

    logic [7:0] exp_val_q[$];
    int         exp_cyc_q[$];
    string      exp_name_q[$];

    clock_reconfig_sequencer_if bus();

    clock_reconfig_sequencer #(
        .BLANK_CYCLES   (4),
        .SETTLE_CYCLES  (8),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .STABLE_CYCLES  (4),
        .MAX_RETRIES    (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts rising edges so that expectations can name an absolute edge.
    always @(posedge clock) cyc <= cyc + 1;

    assign snap = {bus.clock_config_S, bus.pll_reset, bus.output_enable,
                   bus.busy, bus.fault};

    function automatic logic [7:0] outs(input logic [3:0] s, input logic pr,
                                        input logic oe, input logic b,
                                        input logic f);
        outs = {s, pr, oe, b, f};
    endfunction

    task automatic applyStimulus(input logic cc, input logic [3:0] cfg,
                                 input logic locked);
        bus.config_changed  = cc;
        bus.clock_config_in = cfg;
        bus.pll_locked      = locked;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act_val,
                               input int act_cyc, input logic [7:0] exp_val,
                               input int exp_cyc);
        n_compared++;
        if (act_val !== exp_val || act_cyc != exp_cyc) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h at edge %0d, required %h at edge %0d",
                     name, act_val, act_cyc, exp_val, exp_cyc);
        end
    endtask

    task automatic expectEvent(input string name, input logic [7:0] val,
                               input int at);
        exp_name_q.push_back(name);
        exp_val_q.push_back(val);
        exp_cyc_q.push_back(at);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) step();
    endtask

    // Monitor: any output change is a DUT event and is checked against the
    // oldest outstanding expectation.
    always @(negedge clock) begin
        if (armed && snap !== prev) begin
            if (exp_val_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_change: got %h at edge %0d, required no change",
                         snap, cyc);
            end else begin
                checkOutput(exp_name_q.pop_front(), snap, cyc,
                            exp_val_q.pop_front(), exp_cyc_q.pop_front());
            end
        end
        prev = snap;
    end

    initial begin
        int b;
        cyc          = 0;
        armed        = 1'b0;
        prev         = '0;
        n_compared   = 0;
        n_mismatched = 0;

        // Test 1: reset state, then the power-up sequence with lock present.
        reset_n = 1'b0;
        applyStimulus(1'b0, 4'h5, 1'b1);
        step(); step(); step();
        checkOutput("reset_state", snap, cyc, outs(4'h0, 1, 0, 1, 0), cyc);
        armed   = 1'b1;
        reset_n = 1'b1;
        b = cyc;
        $display("[TB] test 1: power-up");
        expectEvent("t1_program_S5",   outs(4'h5, 1, 0, 1, 0), b + 1);
        expectEvent("t1_pll_release",  outs(4'h5, 0, 0, 1, 0), b + 13);
        expectEvent("t1_unblank",      outs(4'h5, 0, 1, 0, 0), b + 18);
        stepTo(b + 22);

        // Test 2: mode change from RUN to setting A.
        $display("[TB] test 2: mode change in RUN");
        b = cyc;
        applyStimulus(1'b1, 4'hA, 1'b1);
        expectEvent("t2_blank",        outs(4'h5, 0, 0, 1, 0), b + 1);
        expectEvent("t2_program",      outs(4'h5, 1, 0, 1, 0), b + 5);
        expectEvent("t2_S_A",          outs(4'hA, 1, 0, 1, 0), b + 6);
        expectEvent("t2_pll_release",  outs(4'hA, 0, 0, 1, 0), b + 18);
        expectEvent("t2_unblank",      outs(4'hA, 0, 1, 0, 0), b + 23);
        step();
        applyStimulus(1'b0, 4'hA, 1'b1);
        stepTo(b + 27);

        // Test 3: lock never arrives. Expect the initial pulse, two retries,
        // then FAULT.
        $display("[TB] test 3: lock never arrives");
        b = cyc;
        applyStimulus(1'b1, 4'hC, 1'b0);
        expectEvent("t3_blank",        outs(4'hA, 0, 0, 1, 0), b + 1);
        expectEvent("t3_program",      outs(4'hA, 1, 0, 1, 0), b + 5);
        expectEvent("t3_S_C",          outs(4'hC, 1, 0, 1, 0), b + 6);
        expectEvent("t3_wait1",        outs(4'hC, 0, 0, 1, 0), b + 18);
        expectEvent("t3_retry1",       outs(4'hC, 1, 0, 1, 0), b + 50);
        expectEvent("t3_wait2",        outs(4'hC, 0, 0, 1, 0), b + 54);
        expectEvent("t3_retry2",       outs(4'hC, 1, 0, 1, 0), b + 86);
        expectEvent("t3_wait3",        outs(4'hC, 0, 0, 1, 0), b + 90);
        expectEvent("t3_fault",        outs(4'hC, 0, 0, 1, 1), b + 122);
        step();
        applyStimulus(1'b0, 4'hC, 1'b0);
        stepTo(b + 130);

        // Test 4: restart out of FAULT. A one-cycle lock glitch in STABLE
        // (STABLE entered at b+19) delays the unblank from b+23 to b+26.
        $display("[TB] test 4: fault restart and stable-window glitch");
        b = cyc;
        applyStimulus(1'b1, 4'h5, 1'b1);
        expectEvent("t4_blank",        outs(4'hC, 0, 0, 1, 0), b + 1);
        expectEvent("t4_program",      outs(4'hC, 1, 0, 1, 0), b + 5);
        expectEvent("t4_S_5",          outs(4'h5, 1, 0, 1, 0), b + 6);
        expectEvent("t4_pll_release",  outs(4'h5, 0, 0, 1, 0), b + 18);
        expectEvent("t4_unblank",      outs(4'h5, 0, 1, 0, 0), b + 26);
        step();
        applyStimulus(1'b0, 4'h5, 1'b1);
        stepTo(b + 20);
        applyStimulus(1'b0, 4'h5, 1'b0);
        step();
        applyStimulus(1'b0, 4'h5, 1'b1);
        stepTo(b + 30);

        // Test 5: a new request during SETTLE restarts at PROGRAM with 3.
        $display("[TB] test 5: request during SETTLE");
        b = cyc;
        applyStimulus(1'b1, 4'h7, 1'b1);
        expectEvent("t5_blank",        outs(4'h5, 0, 0, 1, 0), b + 1);
        expectEvent("t5_program",      outs(4'h5, 1, 0, 1, 0), b + 5);
        expectEvent("t5_S_7",          outs(4'h7, 1, 0, 1, 0), b + 6);
        expectEvent("t5_S_3",          outs(4'h3, 1, 0, 1, 0), b + 11);
        expectEvent("t5_pll_release",  outs(4'h3, 0, 0, 1, 0), b + 23);
        expectEvent("t5_unblank",      outs(4'h3, 0, 1, 0, 0), b + 28);
        step();
        applyStimulus(1'b0, 4'h7, 1'b1);
        stepTo(b + 9);
        applyStimulus(1'b1, 4'h3, 1'b1);
        step();
        applyStimulus(1'b0, 4'h3, 1'b1);
        stepTo(b + 32);

        // Test 6: lock loss in RUN, then a one-cycle reset in WAIT_LOCK
        // reruns power-up.
        $display("[TB] test 6: lock loss then reset mid-WAIT_LOCK");
        b = cyc;
        applyStimulus(1'b0, 4'h9, 1'b0);
        expectEvent("t6_lock_loss",    outs(4'h3, 0, 0, 1, 0), b + 1);
        expectEvent("t6_reset",        outs(4'h0, 1, 0, 1, 0), b + 6);
        expectEvent("t6_S_9",          outs(4'h9, 1, 0, 1, 0), b + 7);
        expectEvent("t6_pll_release",  outs(4'h9, 0, 0, 1, 0), b + 19);
        expectEvent("t6_unblank",      outs(4'h9, 0, 1, 0, 0), b + 24);
        stepTo(b + 5);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        applyStimulus(1'b0, 4'h9, 1'b1);
        stepTo(b + 30);

        // Any expectation still queued was never observed.
        while (exp_val_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s: got no change, required %h at edge %0d",
                     exp_name_q.pop_front(), exp_val_q.pop_front(),
                     exp_cyc_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
